regfile_wb_scan: RTL and testbench



---
 rtl/regfile_wb_scan_if.sv | 31 +++
 rtl/regfile_wb_scan.sv | 130 +++++++++++++
 tb/tb_regfile_wb_scan.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scan_if.sv
// Bus bundle for the write-back register file: write port, two read ports
// and the handshaked register-dump (scan) channel.
interface regfile_wb_scan_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          scan_start;
    logic          scan_ready;
    logic          scan_valid;
    logic [AW-1:0] scan_idx;
    logic [DW-1:0] scan_data;
    logic          scan_busy;
    logic          scan_done;

    modport master (
        output we, wa, wd, ra1, ra2, scan_start, scan_ready,
        input  rd1, rd2, scan_valid, scan_idx, scan_data, scan_busy, scan_done
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, scan_start, scan_ready,
        output rd1, rd2, scan_valid, scan_idx, scan_data, scan_busy, scan_done
    );
endinterface

// File: rtl/regfile_wb_scan.sv
// 2^AW x DW register file with r0 hardwired to zero, write-through bypassed
// read ports, and a sequential scan engine for debug display dumps.
module regfile_wb_scan #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    regfile_wb_scan_if.slave  bus
);
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

    logic [DW-1:0] mem_r [DEPTH];
    logic [1:0]    state_r;
    logic          scan_valid_r;
    logic          scan_busy_r;
    logic          scan_done_r;
    logic [AW-1:0] scan_idx_r;
    logic [DW-1:0] rd1_s;
    logic [DW-1:0] rd2_s;
    logic [DW-1:0] scan_data_s;

    // Register array write; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_ZERO;
            end
        end else if (bus.we && (bus.wa != IDX_ZERO)) begin
            mem_r[bus.wa] <= bus.wd;
        end
    end

    // Read port A with same-cycle write bypass.
    always_comb begin
        rd1_s = DATA_ZERO;
        if (bus.ra1 == IDX_ZERO) begin
            rd1_s = DATA_ZERO;
        end else if (bus.we && (bus.wa == bus.ra1)) begin
            rd1_s = bus.wd;
        end else begin
            rd1_s = mem_r[bus.ra1];
        end
    end

    // Read port B with same-cycle write bypass.
    always_comb begin
        rd2_s = DATA_ZERO;
        if (bus.ra2 == IDX_ZERO) begin
            rd2_s = DATA_ZERO;
        end else if (bus.we && (bus.wa == bus.ra2)) begin
            rd2_s = bus.wd;
        end else begin
            rd2_s = mem_r[bus.ra2];
        end
    end

    // Scan data comes straight from the array: a write shows up after its edge.
    always_comb begin
        scan_data_s = DATA_ZERO;
        if (scan_idx_r == IDX_ZERO) begin
            scan_data_s = DATA_ZERO;
        end else begin
            scan_data_s = mem_r[scan_idx_r];
        end
    end

    // Scan engine; scan_start is only honoured in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            scan_valid_r <= 1'b0;
            scan_busy_r  <= 1'b0;
            scan_done_r  <= 1'b0;
            scan_idx_r   <= IDX_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.scan_start) begin
                        state_r      <= ST_SCAN;
                        scan_valid_r <= 1'b1;
                        scan_busy_r  <= 1'b1;
                        scan_idx_r   <= IDX_ZERO;
                    end
                end
                ST_SCAN: begin
                    if (bus.scan_ready) begin
                        if (scan_idx_r == IDX_LAST) begin
                            state_r      <= ST_DONE;
                            scan_valid_r <= 1'b0;
                            scan_done_r  <= 1'b1;
                        end else begin
                            scan_idx_r <= scan_idx_r + IDX_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    scan_done_r <= 1'b0;
                    scan_busy_r <= 1'b0;
                    scan_idx_r  <= IDX_ZERO;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    scan_valid_r <= 1'b0;
                    scan_busy_r  <= 1'b0;
                    scan_done_r  <= 1'b0;
                    scan_idx_r   <= IDX_ZERO;
                end
            endcase
        end
    end

    assign bus.rd1        = rd1_s;
    assign bus.rd2        = rd2_s;
    assign bus.scan_valid = scan_valid_r;
    assign bus.scan_busy  = scan_busy_r;
    assign bus.scan_done  = scan_done_r;
    assign bus.scan_idx   = scan_idx_r;
    assign bus.scan_data  = scan_data_s;
endmodule

// File: tb/tb_regfile_wb_scan.sv
// Randomized scoreboard bench for regfile_wb_scan: an array model of the
// register set, a queue of expected scan beats and a negedge beat monitor.
module tb_regfile_wb_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_wb_scan_if #(.DW(32), .AW(5)) bus ();

    regfile_wb_scan #(.DW(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          beat_cnt = 0;
    bit          last_beat = 1'b0;
    logic [31:0] model [32];
    int          exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_read(input int ra);
        if (ra == 0) return 32'h0;
        if (bus.we && (int'(bus.wa) == ra)) return bus.wd;
        return model[ra];
    endfunction

    // Called right after an edge on which bus.we was sampled high.
    task automatic commit_write();
        if (bus.we && bus.wa != 5'd0) model[bus.wa] = bus.wd;
    endtask

    // Beat monitor: pops the expected index, checks data against the model.
    always @(negedge clk) begin
        if (rst) begin
            last_beat = 1'b0;
        end else begin
            check("scan_done_pulse", 32'(bus.scan_done), 32'(last_beat));
            last_beat = 1'b0;
            if (bus.scan_valid && bus.scan_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_unexpected: got idx %0d expected no beat", bus.scan_idx);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("beat_idx", 32'(bus.scan_idx), 32'(e));
                    check("beat_data", bus.scan_data, (e == 0) ? 32'h0 : model[e]);
                    last_beat = (e == 31);
                end
            end
        end
    end

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.wa = a; bus.wd = d;
        tick();
        commit_write();
        bus.we = 1'b0;
    endtask

    // mode: 0 = ready tied high, 1 = random ready plus random writes,
    //       2 = directed stall/write/restart features, 3 = async reset at idx 20
    task automatic run_scan(input int mode);
        int  start_beats;
        bit  did7, did10, did15;
        did7 = 1'b0; did10 = 1'b0; did15 = 1'b0;
        start_beats = beat_cnt;
        bus.scan_ready = 1'b1;
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        for (int q = 0; q < 32; q++) exp_q.push_back(q);
        check("scan_start_idx", 32'(bus.scan_idx), 32'd0);
        check("scan_start_busy", 32'(bus.scan_busy), 32'd1);
        for (int c = 0; c < 400; c++) begin
            if (bus.scan_done) begin
                tick();
                check("busy_after_done", 32'(bus.scan_busy), 32'd0);
                check("valid_after_done", 32'(bus.scan_valid), 32'd0);
                check("idx_after_done", 32'(bus.scan_idx), 32'd0);
                check("beat_total", 32'(beat_cnt - start_beats), 32'd32);
                check("queue_drained", 32'(exp_q.size()), 32'd0);
                return;
            end
            if (mode == 3 && bus.scan_idx == 5'd20) begin
                #2 rst = 1'b1;
                #1;
                check("rst_valid", 32'(bus.scan_valid), 32'd0);
                check("rst_busy", 32'(bus.scan_busy), 32'd0);
                check("rst_idx", 32'(bus.scan_idx), 32'd0);
                check("rst_done", 32'(bus.scan_done), 32'd0);
                for (int i = 0; i < 32; i++) model[i] = 32'h0;
                exp_q.delete();
                bus.ra1 = 5'd5;
                #1 check("rst_rd1_r5", bus.rd1, 32'h0);
                #2 rst = 1'b0;
                return;
            end
            if (mode == 2 && !did7 && bus.scan_idx == 5'd7) begin
                did7 = 1'b1;
                bus.scan_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("stall_idx", 32'(bus.scan_idx), 32'd7);
                    check("stall_data", bus.scan_data, 32'h77);
                end
                bus.scan_ready = 1'b1;
                tick();
                check("resume_idx", 32'(bus.scan_idx), 32'd8);
            end else if (mode == 2 && !did10 && bus.scan_idx == 5'd10) begin
                did10 = 1'b1;
                bus.scan_ready = 1'b0;
                bus.we = 1'b1; bus.wa = 5'd10; bus.wd = 32'hCAFEF00D;
                tick();
                commit_write();
                bus.we = 1'b0;
                check("write_under_scan_idx", 32'(bus.scan_idx), 32'd10);
                check("write_under_scan_data", bus.scan_data, 32'hCAFEF00D);
                bus.scan_ready = 1'b1;
                tick();
            end else if (mode == 2 && !did15 && bus.scan_idx == 5'd15) begin
                did15 = 1'b1;
                bus.scan_start = 1'b1;
                tick();
                bus.scan_start = 1'b0;
                check("restart_ignored_busy", 32'(bus.scan_busy), 32'd1);
            end else begin
                bus.scan_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (mode == 1 && $urandom_range(0, 3) == 0) begin
                    bus.we = 1'b1;
                    bus.wa = 5'($urandom_range(0, 31));
                    bus.wd = $urandom();
                end
                tick();
                commit_write();
                bus.we = 1'b0;
            end
        end
        tests++;
        fails++;
        $display("FAIL scan_timeout: got no scan_done expected done within 400 cycles");
        exp_q.delete();
    endtask

    initial begin
        bus.we = 1'b0; bus.wa = 5'd0; bus.wd = 32'h0;
        bus.ra1 = 5'd0; bus.ra2 = 5'd0;
        bus.scan_start = 1'b0; bus.scan_ready = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_valid", 32'(bus.scan_valid), 32'd0);
        check("reset_busy", 32'(bus.scan_busy), 32'd0);
        check("reset_done", 32'(bus.scan_done), 32'd0);
        check("reset_idx", 32'(bus.scan_idx), 32'd0);
        bus.ra1 = 5'd31; bus.ra2 = 5'd1;
        #1 check("reset_rd1", bus.rd1, 32'h0);
        check("reset_rd2", bus.rd2, 32'h0);

        // Basic write then read.
        write_reg(5'd5, 32'hDEADBEEF);
        bus.ra1 = 5'd5; bus.ra2 = 5'd6;
        #1 check("read_r5", bus.rd1, 32'hDEADBEEF);
        check("read_r6", bus.rd2, 32'h0);

        // Bypass, and r0 stays zero even with a same-cycle write.
        bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h12345678; bus.ra1 = 5'd9;
        #1 check("bypass_r9", bus.rd1, 32'h12345678);
        tick();
        commit_write();
        bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF; bus.ra1 = 5'd0;
        #1 check("bypass_r0", bus.rd1, 32'h0);
        tick();
        commit_write();
        bus.we = 1'b0;
        #1 check("after_r0_write", bus.rd1, 32'h0);

        // Load r1..r31 with index*0x11, then a full-speed scan.
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i * 32'h11));
        run_scan(0);
        run_scan(2);
        model[10] = 32'h0; // overwrite r10 back to a known pattern
        write_reg(5'd10, 32'(10 * 32'h11));

        // Random reads with bypass and random writes.
        for (int n = 0; n < 200; n++) begin
            bus.ra1 = 5'($urandom_range(0, 31));
            bus.ra2 = 5'($urandom_range(0, 31));
            bus.we  = 1'($urandom_range(0, 1));
            bus.wa  = ($urandom_range(0, 2) == 0) ? bus.ra1 : 5'($urandom_range(0, 31));
            bus.wd  = $urandom();
            #1 check("rand_rd1", bus.rd1, ref_read(int'(bus.ra1)));
            check("rand_rd2", bus.rd2, ref_read(int'(bus.ra2)));
            tick();
            commit_write();
        end
        bus.we = 1'b0;

        for (int k = 0; k < 3; k++) run_scan(1);

        // Reset mid-scan, then a fresh scan must start at idx 0 over cleared regs.
        write_reg(5'd5, 32'hDEADBEEF);
        run_scan(3);
        tick();
        run_scan(0);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
